// File: rtl/accelerator_hls_deadlock_reporter_if.sv
// ---------------------------------------------------------------------------
// accelerator_hls_deadlock_reporter_if
//
// Report stream carrying the three-word deadlock report toward the host
// debug path. Plain valid/ready handshake with a last marker.
//
// Signals:
//   rpt_valid  report word valid (driven by the reporter)
//   rpt_ready  downstream accept (driven by the consumer)
//   rpt_data   32-bit report word
//   rpt_last   high on the final word of a report
//
// Modports:
//   master  the reporter side
//   slave   the consumer side
// ---------------------------------------------------------------------------
interface accelerator_hls_deadlock_reporter_if;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [31:0] rpt_data;
  logic        rpt_last;

  modport master (
    output rpt_valid,
    output rpt_data,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_data,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/accelerator_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// accelerator_hls_deadlock_reporter
//
// Watches the dataflow deadlock monitor's block indication, confirms a
// deadlock once it has persisted for PERSIST_CYCLES consecutive cycles,
// snapshots the idle/channel-block/AXIS-block status vectors together with a
// free-running timestamp, and sends a three-word report on a valid/ready
// stream. A sticky interrupt and a saturating event counter accompany each
// confirmed deadlock. Exactly one report is produced per deadlock episode.
//
// Ports:
//   clock            sole clock, rising edge
//   reset_n          asynchronous active-low reset
//   block_in         deadlock indication from the monitor
//   axis_block_sigs  AXIS block status (AXIS_W bits)
//   inst_idle_sigs   process idle status (IDLE_W bits)
//   inst_block_sigs  channel block status (BLOCK_W bits)
//   rpt              report stream (master side of the report interface)
//   irq              sticky deadlock interrupt
//   irq_clear        single-cycle clear of irq
//   event_count      confirmed deadlocks since reset, saturating at 255
//   busy             high whenever the FSM is not idle
//
// Report words:
//   0: {8'hDE, event_count (after increment), PERSIST_CYCLES[15:0]}
//   1: zero-extended {axis, block, idle} snapshot, idle in the LSBs
//   2: timestamp snapshot
// ---------------------------------------------------------------------------
module accelerator_hls_deadlock_reporter #(
  parameter int IDLE_W         = 9,
  parameter int BLOCK_W        = 4,
  parameter int AXIS_W         = 2,
  parameter int PERSIST_CYCLES = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                block_in,
  input  logic [AXIS_W-1:0]                   axis_block_sigs,
  input  logic [IDLE_W-1:0]                   inst_idle_sigs,
  input  logic [BLOCK_W-1:0]                  inst_block_sigs,
  accelerator_hls_deadlock_reporter_if.master rpt,
  output logic                                irq,
  input  logic                                irq_clear,
  output logic [7:0]                          event_count,
  output logic                                busy
);

  localparam int          STAT_W       = AXIS_W + BLOCK_W + IDLE_W;
  localparam logic [15:0] PERSIST_LAST = 16'(PERSIST_CYCLES - 1);
  localparam logic [15:0] PERSIST_WORD = 16'(PERSIST_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_SEND0,
    S_SEND1,
    S_SEND2,
    S_HOLD
  } state_t;

  state_t             state_q,       state_d;
  logic [15:0]        pcnt_q,        pcnt_d;
  logic [31:0]        ts_q;
  logic [STAT_W-1:0]  snap_stat_q,   snap_stat_d;
  logic [31:0]        snap_ts_q,     snap_ts_d;
  logic [7:0]         event_count_q, event_count_d;
  logic               irq_q,         irq_d;
  logic               rpt_valid_q,   rpt_valid_d;
  logic [31:0]        rpt_data_q,    rpt_data_d;
  logic               rpt_last_q,    rpt_last_d;
  logic               busy_q,        busy_d;
  logic               confirm;

  // Next-state logic. The persistence counter only runs while the FSM is in
  // IDLE or CONFIRM; the confirm test is shared by both states so that a
  // persistence of one cycle confirms straight from IDLE. All outputs are
  // computed from the next state so they can be registered without adding a
  // cycle of latency.
  always_comb begin
    state_d       = state_q;
    pcnt_d        = '0;
    snap_stat_d   = snap_stat_q;
    snap_ts_d     = snap_ts_q;
    event_count_d = event_count_q;
    irq_d         = irq_q & ~irq_clear;
    confirm       = 1'b0;
    rpt_valid_d   = 1'b0;
    rpt_data_d    = '0;
    rpt_last_d    = 1'b0;

    case (state_q)
      S_IDLE, S_CONFIRM: begin
        if (block_in) begin
          if (pcnt_q == PERSIST_LAST) begin
            confirm = 1'b1;
            state_d = S_SEND0;
          end else begin
            pcnt_d  = pcnt_q + 16'd1;
            state_d = S_CONFIRM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND0: if (rpt.rpt_ready) state_d = S_SEND1;
      S_SEND1: if (rpt.rpt_ready) state_d = S_SEND2;
      S_SEND2: if (rpt.rpt_ready) state_d = S_HOLD;
      // Waiting for the episode to end guarantees one report per deadlock.
      S_HOLD:  if (!block_in)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A confirm outranks a simultaneous irq_clear.
    if (confirm) begin
      snap_stat_d   = {axis_block_sigs, inst_block_sigs, inst_idle_sigs};
      snap_ts_d     = ts_q;
      event_count_d = (event_count_q == 8'hFF) ? 8'hFF : event_count_q + 8'd1;
      irq_d         = 1'b1;
    end

    case (state_d)
      S_SEND0: begin
        rpt_valid_d = 1'b1;
        rpt_data_d  = {8'hDE, event_count_d, PERSIST_WORD};
      end
      S_SEND1: begin
        rpt_valid_d = 1'b1;
        rpt_data_d  = 32'(snap_stat_d);
      end
      S_SEND2: begin
        rpt_valid_d = 1'b1;
        rpt_data_d  = snap_ts_d;
        rpt_last_d  = 1'b1;
      end
      default: begin
        rpt_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, snapshot and registered outputs. The asynchronous reset drops a
  // report in flight immediately; there is no attempt to resume it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pcnt_q        <= '0;
      ts_q          <= '0;
      snap_stat_q   <= '0;
      snap_ts_q     <= '0;
      event_count_q <= '0;
      irq_q         <= 1'b0;
      rpt_valid_q   <= 1'b0;
      rpt_data_q    <= '0;
      rpt_last_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      ts_q          <= ts_q + 32'd1;
      snap_stat_q   <= snap_stat_d;
      snap_ts_q     <= snap_ts_d;
      event_count_q <= event_count_d;
      irq_q         <= irq_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_data_q    <= rpt_data_d;
      rpt_last_q    <= rpt_last_d;
      busy_q        <= busy_d;
    end
  end

  assign rpt.rpt_valid = rpt_valid_q;
  assign rpt.rpt_data  = rpt_data_q;
  assign rpt.rpt_last  = rpt_last_q;
  assign irq           = irq_q;
  assign event_count   = event_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_accelerator_hls_deadlock_reporter.sv
// ---------------------------------------------------------------------------
// tb_accelerator_hls_deadlock_reporter
//
// Self-checking bench for the deadlock reporter. A reference model expresses
// each expected report as a list of words built from the captured status,
// the running event total and the elapsed cycle count since reset release;
// a monitor collects every accepted word for comparison.
// ---------------------------------------------------------------------------
module tb_accelerator_hls_deadlock_reporter;

  localparam int IDLE_W  = 9;
  localparam int BLOCK_W = 4;
  localparam int AXIS_W  = 2;
  localparam int P       = 16;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               block_in = 1'b0;
  logic               irq_clear = 1'b0;
  logic [AXIS_W-1:0]  axis = '0;
  logic [BLOCK_W-1:0] blk = '0;
  logic [IDLE_W-1:0]  idle = '0;
  logic               irq;
  logic               busy;
  logic [7:0]         event_count;

  accelerator_hls_deadlock_reporter_if rptBus ();

  accelerator_hls_deadlock_reporter #(
    .IDLE_W(IDLE_W), .BLOCK_W(BLOCK_W), .AXIS_W(AXIS_W), .PERSIST_CYCLES(P)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .block_in(block_in),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(blk),
    .rpt(rptBus),
    .irq(irq),
    .irq_clear(irq_clear),
    .event_count(event_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          at;
  } word_t;

  word_t       gotQ[$];
  logic [31:0] expData[$];
  logic        expLast[$];
  word_t       monWord;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int cycRelease = 0;
  int modelEvents = 0;

  // Free-running edge count used to derive expected timestamps.
  always @(posedge clock) cyc <= cyc + 1;

  // Collect every word that the consumer accepts on the coming edge.
  always @(negedge clock) begin
    if (reset_n && rptBus.rpt_valid && rptBus.rpt_ready) begin
      monWord.data = rptBus.rpt_data;
      monWord.last = rptBus.rpt_last;
      monWord.at   = cyc;
      gotQ.push_back(monWord);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearQueues();
    gotQ.delete();
    expData.delete();
    expLast.delete();
  endtask

  // Reference model: one confirmed deadlock yields three words.
  function automatic void expectReport(input int evt, input logic [AXIS_W-1:0] a,
                                       input logic [BLOCK_W-1:0] b,
                                       input logic [IDLE_W-1:0] i, input int ts);
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = {8'hDE, 8'(evt), 16'(P)};
    w1 = 32'(i) + (32'(b) << IDLE_W) + (32'(a) << (IDLE_W + BLOCK_W));
    expData.push_back(w0); expLast.push_back(1'b0);
    expData.push_back(w1); expLast.push_back(1'b0);
    expData.push_back(32'(ts)); expLast.push_back(1'b1);
  endfunction

  function automatic void modelConfirm();
    modelEvents = (modelEvents < 255) ? modelEvents + 1 : 255;
    expectReport(modelEvents, axis, blk, idle, cyc - cycRelease);
  endfunction

  // Holds block_in high for highLen cycles with random backpressure, then low
  // until the reporter goes idle. Starts and ends with the reporter idle.
  task automatic applyStimulus(input int highLen, input int readyPct, input bit randStatus);
    int guard;
    for (int k = 0; k < highLen; k++) begin
      block_in = 1'b1;
      if (randStatus) {axis, blk, idle} = 15'($urandom);
      rptBus.rpt_ready = ($urandom_range(99) < readyPct);
      if (k == P - 1) modelConfirm();
      step();
    end
    block_in = 1'b0;
    guard = 0;
    do begin
      rptBus.rpt_ready = ($urandom_range(99) < readyPct);
      step();
      guard++;
    end while (busy && guard < 300);
    rptBus.rpt_ready = 1'b1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_timeout busy=%b required 0 after %0d cycles", busy, guard);
    end
  endtask

  task automatic test_reset();
    rptBus.rpt_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    compared++;
    if ({rptBus.rpt_valid, rptBus.rpt_last, irq, busy} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags valid/last/irq/busy=%b required 0000",
               {rptBus.rpt_valid, rptBus.rpt_last, irq, busy});
    end
    compared++;
    if (rptBus.rpt_data !== 32'h0 || event_count !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data data=%h count=%0d required 0/0", rptBus.rpt_data, event_count);
    end
    reset_n = 1'b1;
    cycRelease = cyc;
    modelEvents = 0;
    step();
    step();
    compared++;
    if ({rptBus.rpt_valid, irq, busy} !== 3'b000 || event_count !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_release valid/irq/busy=%b count=%0d required 000/0",
               {rptBus.rpt_valid, irq, busy}, event_count);
    end
  endtask

  task automatic test_glitch();
    clearQueues();
    for (int k = 0; k < 31; k++) begin
      block_in = (k != 15);
      step();
    end
    block_in = 1'b0;
    repeat (4) step();
    compared++;
    if (gotQ.size() != 0 || irq !== 1'b0 || event_count !== 8'h0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL glitch words=%0d irq=%b count=%0d busy=%b required 0/0/0/0",
               gotQ.size(), irq, event_count, busy);
    end
  endtask

  task automatic test_basic();
    clearQueues();
    rptBus.rpt_ready = 1'b1;
    idle = 9'h1A5; blk = 4'h3; axis = 2'b10;
    for (int i = 0; i < 24; i++) begin
      block_in = (i < 20);
      if (i == P - 1) modelConfirm();
      compared++;
      if (rptBus.rpt_valid !== (i >= 16 && i <= 18) || irq !== (i >= 16) ||
          busy !== (i >= 1 && i <= 20)) begin
        mismatched++;
        $display("[TB] FAIL basic_timing cycle %0d valid/irq/busy=%b%b%b", i,
                 rptBus.rpt_valid, irq, busy);
      end
      if (i >= 16 && i <= 18) begin
        compared++;
        if (rptBus.rpt_data !== expData[i-16] || rptBus.rpt_last !== expLast[i-16]) begin
          mismatched++;
          $display("[TB] FAIL basic_word%0d got %h/%b required %h/%b", i - 16,
                   rptBus.rpt_data, rptBus.rpt_last, expData[i-16], expLast[i-16]);
        end
      end
      if (i == 16) begin
        compared++;
        if (rptBus.rpt_data !== 32'hDE010010) begin
          mismatched++;
          $display("[TB] FAIL basic_word0_const got %h required DE010010", rptBus.rpt_data);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    clearQueues();
    rptBus.rpt_ready = 1'b0;
    for (int k = 0; k < P; k++) begin
      block_in = 1'b1;
      {axis, blk, idle} = 15'($urandom);
      if (k == P - 1) modelConfirm();
      step();
    end
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 6; s++) begin
        {axis, blk, idle} = 15'($urandom);
        rptBus.rpt_ready = (s == 5);
        compared++;
        if (rptBus.rpt_valid !== 1'b1 || rptBus.rpt_data !== expData[w] ||
            rptBus.rpt_last !== expLast[w]) begin
          mismatched++;
          $display("[TB] FAIL bp_stable word%0d stall%0d valid=%b data=%h required 1/%h",
                   w, s, rptBus.rpt_valid, rptBus.rpt_data, expData[w]);
        end
        step();
      end
    end
    compared++;
    if (rptBus.rpt_valid !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_hold valid=%b busy=%b required 0/1", rptBus.rpt_valid, busy);
    end
    block_in = 1'b0;
    rptBus.rpt_ready = 1'b1;
    repeat (3) step();
    compared++;
    if (gotQ.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL bp_count got %0d words required 3", gotQ.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (gotQ[j].data !== expData[j] || gotQ[j].last !== expLast[j]) begin
          mismatched++;
          $display("[TB] FAIL bp_word%0d got %h required %h", j, gotQ[j].data, expData[j]);
        end
      end
    end
  endtask

  task automatic test_long_hold();
    clearQueues();
    applyStimulus(200, 100, 1'b1);
    repeat (3) step();
    applyStimulus(P, 100, 1'b1);
    compared++;
    if (gotQ.size() != expData.size()) begin
      mismatched++;
      $display("[TB] FAIL long_count got %0d words required %0d", gotQ.size(), expData.size());
    end else begin
      for (int j = 0; j < gotQ.size(); j++) begin
        compared++;
        if (gotQ[j].data !== expData[j] || gotQ[j].last !== expLast[j]) begin
          mismatched++;
          $display("[TB] FAIL long_word%0d got %h/%b required %h/%b", j,
                   gotQ[j].data, gotQ[j].last, expData[j], expLast[j]);
        end
      end
    end
  endtask

  task automatic test_irq();
    clearQueues();
    rptBus.rpt_ready = 1'b1;
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL irq_clear got %b required 0", irq);
    end
    for (int k = 0; k < P; k++) begin
      block_in = 1'b1;
      irq_clear = (k == P - 1);
      if (k == P - 1) modelConfirm();
      step();
    end
    irq_clear = 1'b0;
    compared++;
    if (irq !== 1'b1 || rptBus.rpt_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL irq_set_wins irq=%b valid=%b required 1/1", irq, rptBus.rpt_valid);
    end
    step();
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    compared++;
    if (irq !== 1'b0 || rptBus.rpt_valid !== 1'b1 || rptBus.rpt_last !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL irq_later_clear irq=%b valid=%b last=%b required 0/1/1",
               irq, rptBus.rpt_valid, rptBus.rpt_last);
    end
    block_in = 1'b0;
    for (int g = 0; g < 20 && busy; g++) step();
    compared++;
    if (busy !== 1'b0 || gotQ.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL irq_report busy=%b words=%0d required 0/3", busy, gotQ.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (gotQ[j].data !== expData[j]) begin
          mismatched++;
          $display("[TB] FAIL irq_word%0d got %h required %h", j, gotQ[j].data, expData[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    clearQueues();
    for (int e = 0; e < 12; e++) begin
      applyStimulus($urandom_range(40, 1), $urandom_range(100, 30), 1'b1);
      repeat ($urandom_range(3, 1)) step();
    end
    compared++;
    if (gotQ.size() != expData.size()) begin
      mismatched++;
      $display("[TB] FAIL rand_count got %0d words required %0d", gotQ.size(), expData.size());
    end else begin
      for (int j = 0; j < gotQ.size(); j++) begin
        compared++;
        if (gotQ[j].data !== expData[j] || gotQ[j].last !== expLast[j]) begin
          mismatched++;
          $display("[TB] FAIL rand_word%0d got %h/%b required %h/%b", j,
                   gotQ[j].data, gotQ[j].last, expData[j], expLast[j]);
        end
      end
    end
    compared++;
    if (event_count !== 8'(modelEvents)) begin
      mismatched++;
      $display("[TB] FAIL rand_events got %0d required %0d", event_count, modelEvents);
    end
  endtask

  task automatic test_reset_mid_report();
    clearQueues();
    rptBus.rpt_ready = 1'b1;
    for (int k = 0; k < P; k++) begin
      block_in = 1'b1;
      if (k == P - 1) modelConfirm();
      step();
    end
    step();
    rptBus.rpt_ready = 1'b0;
    compared++;
    if (rptBus.rpt_valid !== 1'b1 || rptBus.rpt_data !== expData[1]) begin
      mismatched++;
      $display("[TB] FAIL midrst_send1 valid=%b data=%h required 1/%h",
               rptBus.rpt_valid, rptBus.rpt_data, expData[1]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({rptBus.rpt_valid, rptBus.rpt_last, irq, busy} !== 4'b0000 ||
        rptBus.rpt_data !== 32'h0 || event_count !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL midrst_async valid/last/irq/busy=%b data=%h count=%0d required 0",
               {rptBus.rpt_valid, rptBus.rpt_last, irq, busy}, rptBus.rpt_data, event_count);
    end
    block_in = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    cycRelease = cyc;
    modelEvents = 0;
    rptBus.rpt_ready = 1'b1;
    repeat (5) step();
    compared++;
    if (busy !== 1'b0 || event_count !== 8'h0 || rptBus.rpt_valid !== 1'b0 || gotQ.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL midrst_after busy=%b count=%0d valid=%b words=%0d required 0/0/0/1",
               busy, event_count, rptBus.rpt_valid, gotQ.size());
    end
  endtask

  task automatic test_saturation();
    while (modelEvents < 255) begin
      clearQueues();
      applyStimulus(P, 100, 1'b0);
    end
    compared++;
    if (event_count !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL sat_reach got %0d required 255", event_count);
    end
    clearQueues();
    applyStimulus(P + 3, 100, 1'b1);
    compared++;
    if (event_count !== 8'hFF || gotQ.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL sat_hold count=%0d words=%0d required 255/3", event_count, gotQ.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (gotQ[j].data !== expData[j]) begin
          mismatched++;
          $display("[TB] FAIL sat_word%0d got %h required %h", j, gotQ[j].data, expData[j]);
        end
      end
    end
  endtask

  initial begin
    rptBus.rpt_ready = 1'b1;
    test_reset();
    test_glitch();
    test_basic();
    test_backpressure();
    test_long_hold();
    test_irq();
    test_random();
    test_reset_mid_report();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
